// File: rtl/uart_pkg.sv
// Shared UART types and the fractional baud-step helper used by the TX (and future RX) path.
`timescale 1ns/1ps
package uart_pkg;

  typedef enum logic [1:0] {
    PAR_NONE = 2'd0,
    PAR_EVEN = 2'd1,
    PAR_ODD  = 2'd2
  } parity_e;

  typedef enum logic [2:0] {
    TX_IDLE   = 3'd0,
    TX_START  = 3'd1,
    TX_DATA   = 3'd2,
    TX_PARITY = 3'd3,
    TX_STOP   = 3'd4,
    TX_BREAK  = 3'd5
  } tx_state_e;

  // Rounded phase increment so that the accumulator carries once per bit period.
  function automatic longint unsigned baud_step(input longint unsigned clk_freq,
                                                input longint unsigned baud,
                                                input int unsigned     acc_width);
    return ((baud << (acc_width - 4)) + (clk_freq >> 5)) / (clk_freq >> 4);
  endfunction

endpackage

// File: rtl/uart_tx_param_baud.sv
// Fractional baud-tick generator: phase accumulator whose carry-out is the tick, parked at 0 when disabled.
`timescale 1ns/1ps
module uart_baud_tick_gen
  import uart_pkg::*;
#(
  parameter int CLK_FREQ  = 25000000,
  parameter int BAUD      = 115200,
  parameter int ACC_WIDTH = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  output logic tick
);

  localparam logic [ACC_WIDTH-1:0] STEP = ACC_WIDTH'(baud_step(CLK_FREQ, BAUD, ACC_WIDTH));

  logic [ACC_WIDTH:0]   sum;
  logic [ACC_WIDTH-1:0] acc_q, acc_d;

  // The carry is used combinationally so the first bit after enable lasts a full period.
  assign sum   = {1'b0, acc_q} + {1'b0, STEP};
  assign tick  = enable & sum[ACC_WIDTH];
  assign acc_d = enable ? sum[ACC_WIDTH-1:0] : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) acc_q <= '0;
    else        acc_q <= acc_d;
  end

endmodule

// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter with one-word holding register for zero-gap frames.
// Optional line-break generation is enabled by defining UART_TX_BREAK_EN.
`timescale 1ns/1ps
module uart_tx_param
  import uart_pkg::*;
#(
  parameter int CLK_FREQ  = 25000000,
  parameter int BAUD      = 115200,
  parameter int DATA_BITS = 8,
  parameter int STOP_BITS = 2,
  parameter int PARITY    = 0,
  parameter int ACC_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  input  logic                 tx_break,
  output logic                 txd,
  output logic                 tx_busy
);

  if (CLK_FREQ < 8 * BAUD) begin : g_bad_clk
    $error("uart_tx_param: CLK_FREQ must be at least 8*BAUD");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_bits
    $error("uart_tx_param: DATA_BITS must be 5..9");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
    $error("uart_tx_param: STOP_BITS must be 1 or 2");
  end
  if (PARITY < 0 || PARITY > 2) begin : g_bad_par
    $error("uart_tx_param: PARITY must be 0, 1 or 2");
  end

  localparam int  CNT_W   = 4;
  localparam bit  PAR_EN  = (PARITY != int'(PAR_NONE));
  localparam bit  PAR_INV = (PARITY == int'(PAR_ODD));

  tx_state_e            state_q, state_d;
  logic [CNT_W-1:0]     bit_cnt_q, bit_cnt_d;
  logic                 hold_q, hold_d;
  logic [DATA_BITS-1:0] hold_data_q, hold_data_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_q, par_d;
  logic                 txd_q, txd_d;
  logic                 load, accept, tick, baud_en;

`ifdef UART_TX_BREAK_EN
  assign tx_ready = ~hold_q & (state_q != TX_BREAK) & ~((state_q == TX_IDLE) & tx_break);
  assign baud_en  = (state_q != TX_IDLE) & (state_q != TX_BREAK);
`else
  logic unused_break;
  assign unused_break = tx_break;
  assign tx_ready     = ~hold_q;
  assign baud_en      = (state_q != TX_IDLE);
`endif

  assign accept  = tx_valid & tx_ready;
  assign tx_busy = (state_q != TX_IDLE) | hold_q;
  assign txd     = txd_q;

  uart_baud_tick_gen #(
    .CLK_FREQ (CLK_FREQ),
    .BAUD     (BAUD),
    .ACC_WIDTH(ACC_WIDTH)
  ) u_baud (
    .clk   (clk),
    .rst_n (rst_n),
    .enable(baud_en),
    .tick  (tick)
  );

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    hold_d      = hold_q;
    hold_data_d = hold_data_q;
    shift_d     = shift_q;
    par_d       = par_q;
    load        = 1'b0;

    case (state_q)
      TX_IDLE: begin
        if (hold_q) begin
          load    = 1'b1;
          state_d = TX_START;
        end
`ifdef UART_TX_BREAK_EN
        else if (tx_break) state_d = TX_BREAK;
`endif
      end
      TX_START: if (tick) begin
        state_d   = TX_DATA;
        bit_cnt_d = '0;
      end
      TX_DATA: if (tick) begin
        shift_d = shift_q >> 1;
        if (bit_cnt_q == CNT_W'(DATA_BITS - 1)) begin
          state_d   = PAR_EN ? TX_PARITY : TX_STOP;
          bit_cnt_d = '0;
        end else begin
          bit_cnt_d = bit_cnt_q + 1'b1;
        end
      end
      TX_PARITY: if (tick) begin
        state_d   = TX_STOP;
        bit_cnt_d = '0;
      end
      TX_STOP: if (tick) begin
        if (bit_cnt_q == CNT_W'(STOP_BITS - 1)) begin
          if (hold_q) begin
            load    = 1'b1;
            state_d = TX_START;
          end else begin
            state_d = TX_IDLE;
          end
        end else begin
          bit_cnt_d = bit_cnt_q + 1'b1;
        end
      end
`ifdef UART_TX_BREAK_EN
      TX_BREAK: if (!tx_break) begin
        state_d   = TX_STOP;
        bit_cnt_d = '0;
      end
`endif
      default: state_d = TX_IDLE;
    endcase

    // Parity is taken from the whole word at load time, before shifting starts.
    if (load) begin
      shift_d = hold_data_q;
      par_d   = (^hold_data_q) ^ PAR_INV;
      hold_d  = 1'b0;
    end
    if (accept) begin
      hold_d      = 1'b1;
      hold_data_d = tx_data;
    end

    case (state_d)
      TX_START:  txd_d = 1'b0;
      TX_DATA:   txd_d = shift_d[0];
      TX_PARITY: txd_d = par_d;
      TX_BREAK:  txd_d = 1'b0;
      default:   txd_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= TX_IDLE;
      bit_cnt_q <= '0;
      hold_q    <= 1'b0;
      txd_q     <= 1'b1;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      hold_q    <= hold_d;
      txd_q     <= txd_d;
    end
  end

  always_ff @(posedge clk) begin
    hold_data_q <= hold_data_d;
    shift_q     <= shift_d;
    par_q       <= par_d;
  end

endmodule
